buf_hor_fill_ctrl: RTL
======================

# buf_hor_fill_ctrl

Round-robin fill controller for the horizontal line buffers. It streams one row segment per lane from a single-port activation SRAM into `LANES` 4-entry byte FIFOs (`Sync_v2_FIFO` instances). It arbitrates the SRAM read port between lanes, generates addresses, steers returning data into the correct FIFO, and signals completion to the PU sequencer. The block sits between the SRAM wrapper and the `buff_hor` FIFO bank.

## Interface
- `LANES`, 4: number of FIFOs served (2..8).
- `ADDR_W`, 12: SRAM word-address width.
- `LEN_W`, 8: row-length counter width.
- `DATA_W`, 8: SRAM/FIFO data width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches config and begins a fill; ignored unless IDLE.
- `base_addr`  in  ADDR_W  SRAM address of lane 0 element 0.
- `lane_stride`  in  ADDR_W  address offset between consecutive lanes.
- `row_len`  in  LEN_W  bytes per lane; 0 means no transfer.
- `sram_en`  out  1  read enable to SRAM.
- `sram_addr`  out  ADDR_W  read address.
- `sram_rdata`  in  DATA_W  read data, valid the cycle after `sram_en`.
- `fifo_WREADY`  in  LANES  per-lane not-full from FIFOs.
- `fifo_WVALID`  out  LANES  per-lane write strobe, one-hot or zero.
- `buf_in`  out  DATA_W  shared FIFO write data (= `sram_rdata`).
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: on `start`, latch `base_addr`, `lane_stride` and `row_len`, and clear the per-lane index counters. If `row_len`==0, go to DONE; otherwise go to RUN.
- RUN: each cycle, select at most one eligible lane. Eligible means:
  - `fifo_WREADY[l]`=1,
  - `idx[l]` < `row_len`, and
  - lane `l` was not issued in the previous cycle (one read in flight per lane, so a FIFO showing WREADY at issue cannot overflow).
- Arbitration: round-robin. Search starts at the lane after the last granted lane and wraps at `LANES`-1 → 0. The pointer resets to lane 0.
- On grant: `sram_en`=1, `sram_addr` = `base_addr` + l·`lane_stride` + `idx[l]`, truncated mod 2^ADDR_W (wrap-around allowed, no error). Then `idx[l]`++ and record l in the in-flight register.
- When every lane has `idx`==`row_len` after a grant: go to FLUSH.
- FLUSH: one cycle, for the last return. Then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- With `LANES`=1, the no-back-to-back rule caps throughput at one byte per 2 cycles. This is intended.
- `rst` low at any edge, including mid-fill: all state is cleared, and in-flight data is dropped (no WVALID is issued for it).

## Timing
- Reset values: `sram_en`=0, `sram_addr`=0, `fifo_WVALID`=0, `busy`=0, `done`=0. `buf_in` follows `sram_rdata` combinationally.
- Issue at cycle t ⇒ `fifo_WVALID[l]`=1 (registered) at t+1, with `buf_in`=`sram_rdata` at t+1.
- Peak throughput with ≥2 lanes: one byte/cycle.
- Minimum fill time, ≥2 lanes, never-full FIFOs: LANES·row_len + 3 cycles from `start` to `done` (1 latch cycle + issues + FLUSH + DONE).
- `start` during `busy` is ignored, with no effect on the latched config.
- A lane whose WREADY is low is skipped without stalling other lanes. The arbiter pointer advances only on a grant.

## Configuration
- `BUF_HOR_CTRL_PERF_EN` defined:
  - adds output `stall_cnt` [15:0];
  - `stall_cnt` clears on accepted `start`;
  - it increments, saturating at 16'hFFFF, each RUN cycle with no grant while some lane still has `idx` < `row_len`;
  - it holds after DONE.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1 → all outputs 0, no `sram_en`.
- Basic fill: LANES=4, base=0x100, stride=0x20, row_len=3, WREADY=4'hF →
  - address order 0x100, 0x120, 0x140, 0x160, 0x101, …, 0x162;
  - WVALID one-hot follows one cycle later;
  - `done` 15 cycles after `start`.
- Backpressure: WREADY[1]=0 for cycles 2–9 → lane 1 skipped while other lanes proceed, lane 1 resumes from its own index, total of 12 writes, `done` after the last write + 2 cycles.
- Wrap and zero: base=0xFFE, stride=0x001, row_len=2 → lane 1 addresses 0xFFF and 0x000. row_len=0 → `done` 2 cycles after `start`, no `sram_en`.
- Mid-fill reset and single lane:
  - `rst`=0 at the 5th issue → no WVALID on the next cycle, IDLE;
  - a new `start` restarts at `base_addr`;
  - LANES=1 → `sram_en` is never high in two consecutive cycles.

Source files
------------

// File: rtl/buf_hor_fill_ctrl.sv
// buf_hor_fill_ctrl
// Round-robin fill controller for the horizontal line buffers. On each fill it
// streams row_len bytes per lane from a single-port activation SRAM into LANES
// byte FIFOs. It arbitrates the SRAM read port between lanes, generates read
// addresses, steers the returning data into the right FIFO and pulses done when
// the fill is complete.
//
// Optional build macro: BUF_HOR_CTRL_PERF_EN adds the stall_cnt output, a
// saturating count of RUN cycles in which no lane could be granted.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-low reset
//   start        one-cycle pulse, accepted only while idle
//   base_addr    SRAM address of lane 0 element 0
//   lane_stride  address offset between consecutive lanes
//   row_len      bytes per lane (0 = no transfer)
//   sram_en      SRAM read enable
//   sram_addr    SRAM read address
//   sram_rdata   SRAM read data, valid the cycle after sram_en
//   fifo_WREADY  per-lane FIFO not-full
//   fifo_WVALID  per-lane FIFO write strobe (one-hot or zero)
//   buf_in       shared FIFO write data
//   busy         fill in progress
//   stall_cnt    (BUF_HOR_CTRL_PERF_EN only) stalled RUN cycles
//   done         one-cycle completion pulse
module buf_hor_fill_ctrl #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] lane_stride,
   input  logic [LEN_W-1:0]  row_len,
   output logic              sram_en,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic [LANES-1:0]  fifo_WREADY,
   output logic [LANES-1:0]  fifo_WVALID,
   output logic [DATA_W-1:0] buf_in,
   output logic              busy,
`ifdef BUF_HOR_CTRL_PERF_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              done
);

   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, stride_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx_q [LANES];
   logic [LEN_W-1:0]  idx_d [LANES];
   // Lanes issued last cycle; doubles as the registered write strobe.
   logic [LANES-1:0]  issue_q, issue_d;
   // First lane examined by the next arbitration round.
   logic [LW-1:0]     ptr_q, ptr_d;
   logic              done_q;

   logic [LANES-1:0]  pending;
   logic [LANES-1:0]  elig;
   logic              gnt_vld;
   logic [LW-1:0]     gnt_lane;
   logic              all_done;

   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         pending[l] = idx_q[l] < len_q;
         // A lane issued last cycle still has its read in flight; skipping it
         // keeps WREADY at issue time an accurate overflow guard.
         elig[l]    = fifo_WREADY[l] && pending[l] && !issue_q[l];
      end
   end

   // Round-robin search starting at ptr_q, wrapping at LANES-1.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_lane = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         int unsigned cand;
         cand = 32'(ptr_q) + k;
         if (cand >= LANES) cand = cand - LANES;
         if (!gnt_vld && elig[cand]) begin
            gnt_vld  = 1'b1;
            gnt_lane = LW'(cand);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      issue_d   = '0;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      sram_en   = 1'b0;
      sram_addr = '0;
      all_done  = 1'b1;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ptr_d = '0;
               for (int unsigned l = 0; l < LANES; l++) idx_d[l] = '0;
               state_d = (row_len == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (gnt_vld) begin
               sram_en   = 1'b1;
               // Sum is truncated to ADDR_W, so addresses wrap silently.
               sram_addr = base_q + ADDR_W'(gnt_lane) * stride_q
                         + ADDR_W'(idx_q[gnt_lane]);
               idx_d[gnt_lane]   = idx_q[gnt_lane] + LEN_W'(1);
               issue_d[gnt_lane] = 1'b1;
               ptr_d = (gnt_lane == LW'(LANES - 1)) ? '0 : gnt_lane + LW'(1);
               for (int unsigned l = 0; l < LANES; l++) begin
                  if (idx_d[l] != len_q) all_done = 1'b0;
               end
               if (all_done) state_d = StFlush;
            end
         end
         // One cycle for the final read to return and be written.
         StFlush: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         base_q   <= '0;
         stride_q <= '0;
         len_q    <= '0;
         issue_q  <= '0;
         ptr_q    <= '0;
         done_q   <= 1'b0;
         for (int unsigned l = 0; l < LANES; l++) idx_q[l] <= '0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         done_q  <= (state_q == StDone);
         if (state_q == StIdle && start) begin
            base_q   <= base_addr;
            stride_q <= lane_stride;
            len_q    <= row_len;
         end
      end
   end

   assign fifo_WVALID = issue_q;
   assign buf_in      = sram_rdata;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;

`ifdef BUF_HOR_CTRL_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (state_q == StIdle && start) begin
         stall_q <= '0;
      end else if (state_q == StRun && !gnt_vld && (|pending) && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
